combo_lock_fsm: RTL and testbench
=================================

Name: combo_lock_fsm

Overview:
Code-entry state machine that sits directly downstream of four debounced one-shot button stages. It consumes their multi-cycle press pulses and treats each rising edge as one keypress. It compares the entered sequence against a parameterised code and drives an unlock output. Repeated failures trigger a timed lockout.

Parameters:
CODE_LEN, 4, number of digits per code (2..8)
CODE, 8'b11_10_00_01, packed 2-bit button indices; digit k = CODE[2k+1:2k], digit 0 entered first (default sequence 1,0,2,3)
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1)
UNLOCK_CYCLES, 500, cycles UNLOCK is held high
LOCKOUT_CYCLES, 1000, cycles LOCKED_OUT is held high
ENTRY_TIMEOUT, 5000, idle cycles after a partial entry before the entry is discarded

Ports:
CLK  input  1  clock
RST  input  1  synchronous, active-high reset
BTN_PULSE  input  4  one-shot press pulses; bit i = button i; each pulse may be high for several cycles
UNLOCK  output  1  high while in UNLOCKED
LOCKED_OUT  output  1  high while in LOCKOUT
FAIL_PULSE  output  1  single-cycle strobe on each failed attempt that does not cause lockout
DIGIT_CNT  output  $clog2(CODE_LEN+1)  digits accepted in the current entry
FAIL_CNT  output  $clog2(MAX_FAIL+1)  consecutive failed attempts

Behaviour:
- Reset (RST=1 at posedge):
  - state=ENTRY; UNLOCK=0, LOCKED_OUT=0, FAIL_PULSE=0, DIGIT_CNT=0, FAIL_CNT=0.
  - err flag, timers and timeout counter cleared.
  - Edge register loads the current BTN_PULSE value, so a pulse already high at reset release is not counted.
- Reset has priority over every other event, including mid-entry, mid-UNLOCKED and mid-LOCKOUT.
- Press detection:
  - rise[i] = BTN_PULSE[i] & ~prev[i]; prev updates every cycle in every state.
  - Exactly one rise bit set = valid press of that index.
  - Two or more rise bits in the same cycle = one press that always counts as a mismatch.
  - A held pulse produces only one press.
- ENTRY:
  - On a press, compare the index with digit DIGIT_CNT. A mismatch sets the sticky err flag.
  - DIGIT_CNT increments; the new value is visible the next cycle.
  - No early rejection: all CODE_LEN digits are always collected.
  - A press while DIGIT_CNT==CODE_LEN-1 moves to CHECK next cycle and clears DIGIT_CNT to 0.
- Entry timeout:
  - While DIGIT_CNT>0, a timer counts cycles without a press and restarts on each press.
  - When it reaches ENTRY_TIMEOUT: DIGIT_CNT<=0, err<=0, no fail counted, FAIL_PULSE stays low.
  - While DIGIT_CNT==0 the timer is held at 0.
- CHECK (exactly 1 cycle; presses detected here are ignored):
  - err==0: go to UNLOCKED, FAIL_CNT<=0.
  - err==1 and FAIL_CNT+1==MAX_FAIL: go to LOCKOUT, FAIL_CNT<=MAX_FAIL, no FAIL_PULSE.
  - err==1 otherwise: go to ENTRY, FAIL_CNT+1, FAIL_PULSE=1 for one cycle (registered, coincident with the first ENTRY cycle).
  - err is cleared on leaving CHECK.
- UNLOCKED:
  - UNLOCK=1 for exactly UNLOCK_CYCLES cycles, then back to ENTRY. Presses are ignored.
  - Latency: last-digit rise at cycle t -> CHECK at t+1 -> UNLOCK high from t+2 through t+1+UNLOCK_CYCLES.
- LOCKOUT:
  - LOCKED_OUT=1 for exactly LOCKOUT_CYCLES cycles. Presses are ignored and the timeout timer is idle.
  - Then go to ENTRY with FAIL_CNT<=0.
- Timer arithmetic:
  - Counters sized $clog2(max+1) and saturate; no wrap-around.
  - A press and a timeout expiry in the same cycle: the press wins and is processed normally.

Test Plan:
1. Default params with UNLOCK_CYCLES=8: press 1,0,2,3 using 5-cycle pulses -> DIGIT_CNT steps 1,2,3,0; UNLOCK high exactly 8 cycles starting 2 cycles after the last rise; FAIL_CNT=0.
2. Press 1,0,3,3 -> no UNLOCK; FAIL_PULSE exactly one cycle; FAIL_CNT=1; DIGIT_CNT=0. A following correct 1,0,2,3 -> UNLOCK and FAIL_CNT returns to 0.
3. LOCKOUT_CYCLES=16: three consecutive wrong codes -> FAIL_PULSE twice; on the third failure LOCKED_OUT high exactly 16 cycles with no FAIL_PULSE; a correct code pressed during lockout produces no UNLOCK and DIGIT_CNT stays 0; afterwards FAIL_CNT=0 and a correct code unlocks.
4. Bits 1 and 2 rising in the same cycle as the first digit, then 0,2,3 -> counted as 4 digits, attempt fails, FAIL_CNT=1.
5. ENTRY_TIMEOUT=50: press 1,0, then idle 50 cycles -> DIGIT_CNT returns to 0, FAIL_CNT unchanged, no FAIL_PULSE; then 1,0,2,3 -> UNLOCK.
6. BTN_PULSE[1] high while RST is asserted and still high after release -> no digit counted. Assert RST mid-UNLOCKED -> UNLOCK=0 and all counters 0 on the next cycle.

Source files
------------

// File: rtl/combo_lock_fsm.sv
// Code-entry lock driven by one-shot button pulses. A rising edge on exactly one
// button is a keypress; full entries are judged in CHECK, and repeated failures lock out.
module combo_lock_fsm #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [2*CODE_LEN-1:0] CODE           = 8'b11_10_00_01,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    UNLOCK_CYCLES  = 500,
    parameter int                    LOCKOUT_CYCLES = 1000,
    parameter int                    ENTRY_TIMEOUT  = 5000,
    localparam int                   DW             = $clog2(CODE_LEN + 1),
    localparam int                   FW             = $clog2(MAX_FAIL + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [3:0]    BTN_PULSE,
    output logic          UNLOCK,
    output logic          LOCKED_OUT,
    output logic          FAIL_PULSE,
    output logic [DW-1:0] DIGIT_CNT,
    output logic [FW-1:0] FAIL_CNT
);

    localparam int TW       = $clog2(ENTRY_TIMEOUT + 1);
    localparam int HOLD_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [DW-1:0] LAST_DIGIT   = DW'(CODE_LEN - 1);
    localparam logic [FW-1:0] FAIL_LIMIT   = FW'(MAX_FAIL);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ENTRY_TIMEOUT - 1);
    localparam logic [HW-1:0] UNLOCK_LAST  = HW'(UNLOCK_CYCLES - 1);
    localparam logic [HW-1:0] LOCKOUT_LAST = HW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTRY,
        CHECK,
        UNLOCKED,
        LOCKOUT
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    btnPrev_q;
    logic [DW-1:0] digitCnt_q, digitCnt_d;
    logic          err_q, err_d;
    logic [FW-1:0] failCnt_q, failCnt_d;
    logic          failPulse_q, failPulse_d;
    logic [TW-1:0] idleTmr_q, idleTmr_d;
    logic [HW-1:0] holdTmr_q, holdTmr_d;

    logic [3:0]    rise;
    logic          pressValid;
    logic          singlePress;
    logic [1:0]    pressIdx;
    logic [1:0]    expectDigit;

    // Simultaneous rises are still one keypress, but one that can never match.
    always_comb begin
        rise        = BTN_PULSE & ~btnPrev_q;
        pressValid  = |rise;
        singlePress = 1'b1;
        pressIdx    = 2'd0;
        case (rise)
            4'b0001: pressIdx = 2'd0;
            4'b0010: pressIdx = 2'd1;
            4'b0100: pressIdx = 2'd2;
            4'b1000: pressIdx = 2'd3;
            default: singlePress = 1'b0;
        endcase
    end

    always_comb begin
        expectDigit = 2'd0;
        for (int k = 0; k < CODE_LEN; k++) begin
            if (digitCnt_q == DW'(k)) begin
                expectDigit = CODE[2*k +: 2];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        digitCnt_d  = digitCnt_q;
        err_d       = err_q;
        failCnt_d   = failCnt_q;
        failPulse_d = 1'b0;
        idleTmr_d   = '0;
        holdTmr_d   = '0;

        case (state_q)
            ENTRY: begin
                if (pressValid) begin
                    if (!singlePress || (pressIdx != expectDigit)) begin
                        err_d = 1'b1;
                    end
                    if (digitCnt_q == LAST_DIGIT) begin
                        state_d    = CHECK;
                        digitCnt_d = '0;
                    end else begin
                        digitCnt_d = digitCnt_q + DW'(1);
                    end
                end else if (digitCnt_q != '0) begin
                    // An abandoned partial entry is dropped silently, not counted as a failure.
                    if (idleTmr_q >= TIMEOUT_LAST) begin
                        digitCnt_d = '0;
                        err_d      = 1'b0;
                    end else begin
                        idleTmr_d = idleTmr_q + TW'(1);
                    end
                end
            end

            CHECK: begin
                err_d = 1'b0;
                if (!err_q) begin
                    state_d   = UNLOCKED;
                    failCnt_d = '0;
                end else if ((failCnt_q + FW'(1)) == FAIL_LIMIT) begin
                    state_d   = LOCKOUT;
                    failCnt_d = FAIL_LIMIT;
                end else begin
                    state_d     = ENTRY;
                    failCnt_d   = failCnt_q + FW'(1);
                    failPulse_d = 1'b1;
                end
            end

            UNLOCKED: begin
                if (holdTmr_q >= UNLOCK_LAST) begin
                    state_d = ENTRY;
                end else begin
                    holdTmr_d = holdTmr_q + HW'(1);
                end
            end

            LOCKOUT: begin
                if (holdTmr_q >= LOCKOUT_LAST) begin
                    state_d   = ENTRY;
                    failCnt_d = '0;
                end else begin
                    holdTmr_d = holdTmr_q + HW'(1);
                end
            end

            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    // The edge register also loads on reset so a pulse held across reset release is ignored.
    always_ff @(posedge CLK) begin
        btnPrev_q <= BTN_PULSE;
        if (RST) begin
            state_q     <= ENTRY;
            digitCnt_q  <= '0;
            err_q       <= 1'b0;
            failCnt_q   <= '0;
            failPulse_q <= 1'b0;
            idleTmr_q   <= '0;
            holdTmr_q   <= '0;
        end else begin
            state_q     <= state_d;
            digitCnt_q  <= digitCnt_d;
            err_q       <= err_d;
            failCnt_q   <= failCnt_d;
            failPulse_q <= failPulse_d;
            idleTmr_q   <= idleTmr_d;
            holdTmr_q   <= holdTmr_d;
        end
    end

    assign UNLOCK     = (state_q == UNLOCKED);
    assign LOCKED_OUT = (state_q == LOCKOUT);
    assign FAIL_PULSE = failPulse_q;
    assign DIGIT_CNT  = digitCnt_q;
    assign FAIL_CNT   = failCnt_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Testbench for combo_lock_fsm: scheduled and random button traffic compared cycle by
// cycle against a queue-based model of the lock, plus targeted scenario checks.
module tb_combo_lock_fsm;

    localparam int         CODE_LEN       = 4;
    localparam logic [7:0] CODE           = 8'b11_10_00_01;
    localparam int         MAX_FAIL       = 3;
    localparam int         UNLOCK_CYCLES  = 8;
    localparam int         LOCKOUT_CYCLES = 16;
    localparam int         ENTRY_TIMEOUT  = 50;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] BTN_PULSE = 4'b0000;
    logic       UNLOCK;
    logic       LOCKED_OUT;
    logic       FAIL_PULSE;
    logic [2:0] DIGIT_CNT;
    logic [1:0] FAIL_CNT;

    combo_lock_fsm #(
        .CODE_LEN      (CODE_LEN),
        .CODE          (CODE),
        .MAX_FAIL      (MAX_FAIL),
        .UNLOCK_CYCLES (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
        .ENTRY_TIMEOUT (ENTRY_TIMEOUT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BTN_PULSE (BTN_PULSE),
        .UNLOCK    (UNLOCK),
        .LOCKED_OUT(LOCKED_OUT),
        .FAIL_PULSE(FAIL_PULSE),
        .DIGIT_CNT (DIGIT_CNT),
        .FAIL_CNT  (FAIL_CNT)
    );

    always #5 CLK = ~CLK;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] sched[$];
    logic [7:0] obs[$];
    logic [7:0] expQ[$];

    // Reference model: entered digits kept as a queue, judged as a whole sequence.
    int         mDigits[$];
    int         mAttempt[$];
    logic [3:0] mPrev = 4'b0000;
    int         mIdle = 0;
    int         mFailCnt = 0;
    int         mUnlockLeft = 0;
    int         mLockLeft = 0;
    bit         mCheck = 1'b0;
    bit         mFailPulse = 1'b0;

    function automatic int codeDigit(input int k);
        return int'((CODE >> (2 * k)) & 8'd3);
    endfunction

    function automatic logic [3:0] bit4(input int d);
        return 4'(1 << d);
    endfunction

    task automatic modelStep(input logic rst, input logic [3:0] btn);
        logic [3:0] rise;
        bit         ok;
        int         idx;
        if (rst) begin
            mDigits.delete();
            mAttempt.delete();
            mPrev       = btn;
            mIdle       = 0;
            mFailCnt    = 0;
            mUnlockLeft = 0;
            mLockLeft   = 0;
            mCheck      = 1'b0;
            mFailPulse  = 1'b0;
        end else begin
            rise       = btn & ~mPrev;
            mPrev      = btn;
            mFailPulse = 1'b0;
            if (mCheck) begin
                mCheck = 1'b0;
                ok     = 1'b1;
                foreach (mAttempt[k]) if (mAttempt[k] != codeDigit(k)) ok = 1'b0;
                if (ok) begin
                    mUnlockLeft = UNLOCK_CYCLES;
                    mFailCnt    = 0;
                end else if (mFailCnt + 1 == MAX_FAIL) begin
                    mLockLeft = LOCKOUT_CYCLES;
                    mFailCnt  = MAX_FAIL;
                end else begin
                    mFailCnt++;
                    mFailPulse = 1'b1;
                end
            end else if (mUnlockLeft > 0) begin
                mUnlockLeft--;
            end else if (mLockLeft > 0) begin
                mLockLeft--;
                if (mLockLeft == 0) mFailCnt = 0;
            end else if (rise != 4'b0000) begin
                idx = -1;
                if ($countones(rise) == 1) begin
                    for (int b = 0; b < 4; b++) if (rise[b]) idx = b;
                end
                mDigits.push_back(idx);
                mIdle = 0;
                if (mDigits.size() == CODE_LEN) begin
                    mAttempt = mDigits;
                    mDigits.delete();
                    mCheck = 1'b1;
                end
            end else if (mDigits.size() > 0) begin
                mIdle++;
                if (mIdle >= ENTRY_TIMEOUT) begin
                    mDigits.delete();
                    mIdle = 0;
                end
            end
        end
    endtask

    function automatic logic [7:0] modelVec();
        return {mUnlockLeft > 0, mLockLeft > 0, mFailPulse, 3'(mDigits.size()), 2'(mFailCnt)};
    endfunction

    function automatic logic [7:0] dutVec();
        return {UNLOCK, LOCKED_OUT, FAIL_PULSE, DIGIT_CNT, FAIL_CNT};
    endfunction

    function automatic int countBit(input int b);
        int n = 0;
        foreach (obs[i]) if (obs[i][b]) n++;
        return n;
    endfunction

    task automatic cycle();
        @(posedge CLK);
        modelStep(RST, BTN_PULSE);
        @(negedge CLK);
    endtask

    task automatic addPress(input logic [3:0] mask, input int hold, input int gap);
        repeat (hold) sched.push_back({1'b0, mask});
        repeat (gap) sched.push_back(5'b0_0000);
    endtask

    task automatic addIdle(input int n);
        repeat (n) sched.push_back(5'b0_0000);
    endtask

    task automatic addCode(input int a, input int b, input int c, input int d,
                           input int hold, input int gap);
        int seq[4] = '{a, b, c, d};
        for (int k = 0; k < 4; k++) begin
            addPress(bit4(seq[k]), (hold > 0) ? hold : int'($urandom_range(1, 5)),
                     (gap > 0) ? gap : int'($urandom_range(1, 3)));
        end
    endtask

    // Drives the pending schedule and records DUT and model outputs after each edge.
    task automatic runSched();
        obs.delete();
        expQ.delete();
        while (sched.size() > 0) begin
            {RST, BTN_PULSE} = sched.pop_front();
            cycle();
            obs.push_back(dutVec());
            expQ.push_back(modelVec());
        end
    endtask

    task automatic test_reset();
        repeat (3) sched.push_back(5'b1_0000);
        addIdle(2);
        runSched();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL reset_seq cycle %0d: got {unl,lck,fp,dcnt,fcnt}=%b expected %b", i, obs[i], expQ[i]);
            end
        end
        checks++;
        if (obs[2] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_state: got %b expected 00000000", obs[2]);
        end
    endtask

    task automatic test_unlock();
        int rise[4];
        int digits[4] = '{1, 0, 2, 3};
        int expCnt[4] = '{1, 2, 3, 0};
        int first = -1;
        for (int k = 0; k < 4; k++) begin
            rise[k] = sched.size();
            addPress(bit4(digits[k]), 5, $urandom_range(1, 4));
        end
        addIdle(14);
        runSched();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL unlock_seq cycle %0d: got {unl,lck,fp,dcnt,fcnt}=%b expected %b", i, obs[i], expQ[i]);
            end
            if (first < 0 && obs[i][7]) first = i;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (int'(obs[rise[k]][4:2]) !== expCnt[k]) begin
                errors++;
                $display("[TB] FAIL unlock_digit_cnt press %0d: got %0d expected %0d", k, obs[rise[k]][4:2], expCnt[k]);
            end
        end
        checks++;
        if (countBit(7) !== UNLOCK_CYCLES) begin
            errors++;
            $display("[TB] FAIL unlock_len: got %0d expected %0d", countBit(7), UNLOCK_CYCLES);
        end
        // obs[i] is sampled in the cycle after the edge that sampled stimulus i.
        checks++;
        if ((first + 1) - rise[3] !== 2) begin
            errors++;
            $display("[TB] FAIL unlock_latency: got %0d expected 2", (first + 1) - rise[3]);
        end
        checks++;
        if (obs[$][1:0] !== 2'd0) begin
            errors++;
            $display("[TB] FAIL unlock_fail_cnt: got %0d expected 0", obs[$][1:0]);
        end
    endtask

    task automatic test_wrong_code();
        int mid;
        addCode(1, 0, 3, 3, 5, 2);
        addIdle(6);
        mid = sched.size();
        addCode(1, 0, 2, 3, 0, 0);
        addIdle(14);
        runSched();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL wrong_seq cycle %0d: got {unl,lck,fp,dcnt,fcnt}=%b expected %b", i, obs[i], expQ[i]);
            end
        end
        checks++;
        if (countBit(5) !== 1) begin
            errors++;
            $display("[TB] FAIL wrong_fail_pulses: got %0d expected 1", countBit(5));
        end
        checks++;
        if (obs[mid-1][4:0] !== {3'd0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL wrong_counts: got dcnt=%0d fcnt=%0d expected dcnt=0 fcnt=1", obs[mid-1][4:2], obs[mid-1][1:0]);
        end
        checks++;
        if (countBit(7) !== UNLOCK_CYCLES) begin
            errors++;
            $display("[TB] FAIL wrong_then_unlock: got %0d expected %0d", countBit(7), UNLOCK_CYCLES);
        end
        checks++;
        if (obs[$][1:0] !== 2'd0) begin
            errors++;
            $display("[TB] FAIL wrong_fail_clear: got %0d expected 0", obs[$][1:0]);
        end
    endtask

    task automatic test_lockout();
        int lockedDigits = 0;
        int firstLock = -1;
        addCode(0, 0, 0, 0, 0, 0);
        addIdle(4);
        addCode(1, 0, 2, 2, 0, 0);
        addIdle(4);
        addCode(3, 2, 1, 0, 1, 2);
        addCode(1, 0, 2, 3, 1, 1);
        addIdle(12);
        addCode(1, 0, 2, 3, 0, 0);
        addIdle(14);
        runSched();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL lockout_seq cycle %0d: got {unl,lck,fp,dcnt,fcnt}=%b expected %b", i, obs[i], expQ[i]);
            end
            if (obs[i][6] && obs[i][4:2] != 3'd0) lockedDigits++;
            if (firstLock < 0 && obs[i][6]) firstLock = i;
        end
        checks++;
        if (countBit(5) !== 2) begin
            errors++;
            $display("[TB] FAIL lockout_fail_pulses: got %0d expected 2", countBit(5));
        end
        checks++;
        if (countBit(6) !== LOCKOUT_CYCLES) begin
            errors++;
            $display("[TB] FAIL lockout_len: got %0d expected %0d", countBit(6), LOCKOUT_CYCLES);
        end
        checks++;
        if (firstLock < 0 || obs[firstLock][1:0] !== 2'd3) begin
            errors++;
            $display("[TB] FAIL lockout_fail_cnt: got %0d expected 3", (firstLock < 0) ? 0 : int'(obs[firstLock][1:0]));
        end
        checks++;
        if (lockedDigits !== 0) begin
            errors++;
            $display("[TB] FAIL lockout_digits: got %0d cycles with digits expected 0", lockedDigits);
        end
        checks++;
        if (countBit(7) !== UNLOCK_CYCLES || obs[$][1:0] !== 2'd0) begin
            errors++;
            $display("[TB] FAIL lockout_recover: got unlock=%0d fcnt=%0d expected unlock=%0d fcnt=0", countBit(7), obs[$][1:0], UNLOCK_CYCLES);
        end
    endtask

    task automatic test_multi_press();
        int m;
        m = sched.size();
        addPress(4'b0110, 5, 2);
        addPress(bit4(0), 5, 2);
        addPress(bit4(2), 5, 2);
        addPress(bit4(3), 5, 2);
        addIdle(6);
        runSched();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL multi_seq cycle %0d: got {unl,lck,fp,dcnt,fcnt}=%b expected %b", i, obs[i], expQ[i]);
            end
        end
        checks++;
        if (obs[m][4:2] !== 3'd1) begin
            errors++;
            $display("[TB] FAIL multi_counted: got %0d expected 1", obs[m][4:2]);
        end
        checks++;
        if (countBit(5) !== 1 || countBit(7) !== 0 || obs[$][1:0] !== 2'd1) begin
            errors++;
            $display("[TB] FAIL multi_result: got fp=%0d unl=%0d fcnt=%0d expected fp=1 unl=0 fcnt=1", countBit(5), countBit(7), obs[$][1:0]);
        end
    endtask

    task automatic test_timeout();
        int r2;
        int mid;
        int pulses = 0;
        addPress(bit4(1), 5, 2);
        r2 = sched.size();
        addPress(bit4(0), 5, 0);
        addIdle(60);
        mid = sched.size();
        addCode(1, 0, 2, 3, 0, 0);
        addIdle(14);
        runSched();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL timeout_seq cycle %0d: got {unl,lck,fp,dcnt,fcnt}=%b expected %b", i, obs[i], expQ[i]);
            end
            if (i < mid && obs[i][5]) pulses++;
        end
        checks++;
        if (obs[r2+40][4:2] !== 3'd2) begin
            errors++;
            $display("[TB] FAIL timeout_early: got %0d expected 2", obs[r2+40][4:2]);
        end
        checks++;
        if (obs[mid-1][4:0] !== {3'd0, 2'd1} || pulses !== 0) begin
            errors++;
            $display("[TB] FAIL timeout_discard: got dcnt=%0d fcnt=%0d fp=%0d expected dcnt=0 fcnt=1 fp=0", obs[mid-1][4:2], obs[mid-1][1:0], pulses);
        end
        checks++;
        if (countBit(7) !== UNLOCK_CYCLES) begin
            errors++;
            $display("[TB] FAIL timeout_then_unlock: got %0d expected %0d", countBit(7), UNLOCK_CYCLES);
        end
    endtask

    task automatic test_reset_cases();
        int seg;
        int rstIdx;
        repeat (3) sched.push_back({1'b1, bit4(1)});
        repeat (5) sched.push_back({1'b0, bit4(1)});
        addIdle(2);
        seg = sched.size();
        addCode(1, 0, 2, 3, 2, 1);
        addIdle(4);
        rstIdx = sched.size();
        sched.push_back(5'b1_0000);
        addIdle(3);
        runSched();
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expQ[i]) begin
                errors++;
                $display("[TB] FAIL rstcase_seq cycle %0d: got {unl,lck,fp,dcnt,fcnt}=%b expected %b", i, obs[i], expQ[i]);
            end
        end
        checks++;
        if (obs[seg-1] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL held_pulse_ignored: got %b expected 00000000", obs[seg-1]);
        end
        checks++;
        if (obs[rstIdx-1][7] !== 1'b1 || countBit(7) !== 6) begin
            errors++;
            $display("[TB] FAIL rst_mid_unlock_len: got %0d expected 6", countBit(7));
        end
        checks++;
        if (obs[rstIdx] !== 8'h00 || obs[rstIdx+1] !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rst_mid_unlock: got %b/%b expected 00000000", obs[rstIdx], obs[rstIdx+1]);
        end
    endtask

    task automatic test_random();
        int         kind;
        int         hold;
        int         gap;
        logic [3:0] mask;
        for (int ev = 0; ev < 250; ev++) begin
            kind = $urandom_range(0, 19);
            hold = $urandom_range(1, 6);
            gap  = $urandom_range(1, 5);
            if (kind == 0) begin
                mask = 4'($urandom);
                repeat ($urandom_range(1, 2)) sched.push_back({1'b1, mask});
                addIdle(gap);
            end else if (kind == 1) begin
                addIdle($urandom_range(30, 70));
            end else begin
                if (kind == 2) begin
                    do mask = 4'($urandom); while ($countones(mask) < 2);
                end else if (kind < 10) begin
                    mask = bit4($urandom_range(0, 3));
                end else begin
                    mask = bit4((mDigits.size() < CODE_LEN) ? codeDigit(mDigits.size()) : 0);
                end
                addPress(mask, hold, gap);
            end
            runSched();
            foreach (obs[i]) begin
                checks++;
                if (obs[i] !== expQ[i]) begin
                    errors++;
                    $display("[TB] FAIL random ev %0d cycle %0d: got {unl,lck,fp,dcnt,fcnt}=%b expected %b", ev, i, obs[i], expQ[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_wrong_code();
        test_lockout();
        test_multi_press();
        test_timeout();
        test_reset_cases();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
